// File: rtl/pow_5_root_pkg.sv
// Shared types and constants for the fifth-root extractor.
package pow_5_root_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2
  } state_t;

  // Four multiplies take the seeded prod (= cand) up to cand^5.
  localparam int unsigned MUL_STEPS = 4;

  function automatic int unsigned root_width(input int unsigned x_width);
    return (x_width + 4) / 5;
  endfunction

endpackage

// File: rtl/pow_5_root.sv
// Sequential floor(x^(1/5)): bit-serial restoring search, one candidate per 5 cycles.
module pow_5_root
  import pow_5_root_pkg::*;
#(
  parameter int unsigned X_WIDTH    = 32,
  parameter int unsigned ROOT_WIDTH = root_width(X_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [X_WIDTH-1:0]    x,
  output logic                  ready,
  output logic                  busy,
  output logic [ROOT_WIDTH-1:0] root
);

  localparam int unsigned PW = 5 * ROOT_WIDTH;
  localparam int unsigned IW = (ROOT_WIDTH > 1) ? $clog2(ROOT_WIDTH) : 1;
  localparam logic [1:0]  MCNT_LAST = 2'(MUL_STEPS - 1);

  state_t                r_state;
  logic [X_WIDTH-1:0]    r_x;
  logic [ROOT_WIDTH-1:0] r_acc;
  logic [IW-1:0]         r_bit_idx;
  logic [ROOT_WIDTH-1:0] r_cand;
  logic [PW-1:0]         r_prod;
  logic [1:0]            r_mcnt;
  logic                  r_ready;
  logic                  r_busy;
  logic [ROOT_WIDTH-1:0] r_root;

  logic [PW-1:0]         w_mul;
  logic                  w_keep;
  logic [ROOT_WIDTH-1:0] w_acc_next;
  logic [ROOT_WIDTH-1:0] w_cand_next;
  logic [ROOT_WIDTH-1:0] w_cand_first;

  // Truncation is exact: prod never exceeds cand^4 before a multiply.
  assign w_mul        = r_prod * PW'(r_cand);
  assign w_keep       = (r_prod <= PW'(r_x));
  assign w_acc_next   = w_keep ? r_cand : r_acc;
  assign w_cand_next  = w_acc_next | (ROOT_WIDTH'(1) << (r_bit_idx - IW'(1)));
  assign w_cand_first = ROOT_WIDTH'(1) << (ROOT_WIDTH - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_acc     <= '0;
      r_bit_idx <= '0;
      r_cand    <= '0;
      r_prod    <= '0;
      r_mcnt    <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_root    <= '0;
    end else begin
      r_ready <= 1'b0;
      if (run) begin
        // A new run always wins, restarting any computation in flight.
        r_x       <= x;
        r_acc     <= '0;
        r_bit_idx <= IW'(ROOT_WIDTH - 1);
        r_cand    <= w_cand_first;
        r_prod    <= PW'(w_cand_first);
        r_mcnt    <= '0;
        r_state   <= MUL;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          MUL: begin
            r_prod <= w_mul;
            r_mcnt <= r_mcnt + 2'd1;
            if (r_mcnt == MCNT_LAST) r_state <= CMP;
          end
          CMP: begin
            r_acc <= w_acc_next;
            if (r_bit_idx == '0) begin
              r_root  <= w_acc_next;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_bit_idx <= r_bit_idx - IW'(1);
              r_cand    <= w_cand_next;
              r_prod    <= PW'(w_cand_next);
              r_mcnt    <= '0;
              r_state   <= MUL;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign root  = r_root;

endmodule

// File: tb/tb_pow_5_root.sv
// Randomized self-checking bench for pow_5_root against an arithmetic fifth-root model.
module tb_pow_5_root;

  localparam int unsigned XW  = 32;
  localparam int unsigned RW  = 7;
  localparam int unsigned LAT = 35;

  logic          clock;
  logic          reset_n;
  logic          run;
  logic [XW-1:0] x;
  logic          ready;
  logic          busy;
  logic [RW-1:0] root;

  int unsigned n_checks;
  int unsigned n_fail;

  pow_5_root #(.X_WIDTH(XW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .x       (x),
    .ready   (ready),
    .busy    (busy),
    .root    (root)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic longint unsigned pow5(input longint unsigned n);
    return n * n * n * n * n;
  endfunction

  // Largest r with r^5 <= v, by linear search.
  function automatic longint unsigned ref_root(input longint unsigned v);
    longint unsigned r = 0;
    while (pow5(r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [XW-1:0] xv);
    @(posedge clock); #1;
    run = 1'b1;
    x   = xv;
    @(posedge clock); #1;
    run = 1'b0;
    x   = $urandom;
  endtask

  // Observes 40 cycles after the run edge: one ready pulse at LAT, busy shape, held root.
  task automatic finish_op(input string tag, input longint unsigned exp_root);
    int unsigned pulses = 0;
    int unsigned first  = 0;
    longint unsigned root_at_pulse = 0;
    bit busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (ready) begin
        pulses++;
        if (first == 0) begin
          first = k;
          root_at_pulse = root;
        end
      end
      if (k < LAT && !busy) busy_ok = 1'b0;
      if (k >= LAT && busy) busy_ok = 1'b0;
      if (k % 7 == 0) x = $urandom;
    end
    check({tag, "/latency"}, first, LAT);
    check({tag, "/pulses"}, pulses, 1);
    check({tag, "/busy"}, busy_ok, 1);
    check({tag, "/root"}, root_at_pulse, exp_root);
    check({tag, "/hold"}, root, exp_root);
  endtask

  task automatic do_op(input string tag, input logic [XW-1:0] xv, input longint unsigned exp_root);
    start(xv);
    finish_op(tag, exp_root);
  endtask

  initial begin
    logic [XW-1:0] xv;
    longint unsigned n;
    int unsigned bad;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    run      = 1'b0;
    x        = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset/ready", ready, 0);
    check("reset/busy", busy, 0);
    check("reset/root", root, 0);
    reset_n = 1'b1;

    do_op("x0", 32'd0, 0);
    do_op("x1", 32'd1, 1);
    do_op("x31", 32'd31, 1);
    do_op("x32", 32'd32, 2);
    do_op("x242", 32'd242, 2);
    do_op("x243", 32'd243, 3);
    do_op("xmax", 32'hFFFF_FFFF, 84);
    do_op("x84p5", 32'd4182119424, 84);
    do_op("x84p5m1", 32'd4182119423, 83);

    for (int i = 0; i <= 12; i++)
      do_op($sformatf("chain%0d", i), XW'(pow5(longint'(i))), longint'(i));

    // Restart: the first run must never complete.
    start(32'd243);
    bad = 0;
    repeat (9) begin
      @(posedge clock); #1;
      if (ready) bad++;
    end
    check("restart/early_ready", bad, 0);
    do_op("restart", 32'd32, 2);

    // Async reset mid-operation, with a non-zero root left from the previous op.
    start(32'hFFFF_FFFF);
    repeat (16) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst/root", root, 0);
    check("arst/busy", busy, 0);
    check("arst/ready", ready, 0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (ready || busy || root != '0) bad++;
    end
    check("arst/quiet", bad, 0);
    do_op("x1024", 32'd1024, 4);

    // Run held high keeps restarting and never completes.
    @(posedge clock); #1;
    run = 1'b1;
    bad = 0;
    repeat (50) begin
      x = $urandom;
      @(posedge clock); #1;
      if (ready || !busy) bad++;
    end
    run = 1'b0;
    check("run_held", bad, 0);
    finish_op("run_held_release", ref_root(longint'(x)));

    for (int i = 0; i < 20; i++) begin
      xv = $urandom;
      if (i % 4 == 1) xv = xv >> $urandom_range(31, 1);
      do_op($sformatf("rand%0d", i), xv, ref_root(longint'(xv)));
    end

    for (int i = 0; i < 10; i++) begin
      n  = longint'($urandom_range(84, 1));
      xv = XW'(pow5(n));
      do_op($sformatf("exact%0d", i), xv, n);
      do_op($sformatf("below%0d", i), xv - 1, n - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
